// File: rtl/pu_pkg.sv
// pu_pkg: shared state encodings, PU phase encodings and drain-length helper for pu_seq
package pu_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [1:0] CAL_IDLE = 2'b00;
  localparam logic [1:0] CAL_MAC  = 2'b10;
  localparam logic [1:0] CAL_BIAS = 2'b11;
  function automatic int drain_cyc(input int rows, input int cols);
    return rows + cols - 1;
  endfunction
endpackage

// File: rtl/pu_seq_cnt.sv
// pu_seq_cnt: loadable up-counter with terminal-count flag (clk, rst, ld/ld_val load, inc step, term compare value; cnt value, tc at term)
module pu_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (inc) cnt <= cnt + 1'b1;
  assign tc = cnt == term;
endmodule

// File: rtl/pu_seq.sv
// pu_seq: layer/tile/K sequencer for a systolic PU (clk, rst, i_start + i_num_layers/i_num_tiles/i_k_len config, i_rd_vld/o_rd_req operand beats, o_wr_vld/i_wr_rdy writeback, o_en_tf/o_cal_state PU control, o_layer_state/o_tile_idx position, o_busy/o_done status)
module pu_seq
  import pu_pkg::*;
#(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int CNT_BW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [2:0]        i_num_layers,
  input  logic [CNT_BW-1:0] i_num_tiles,
  input  logic [CNT_BW-1:0] i_k_len,
  input  logic              i_rd_vld,
  output logic              o_rd_req,
  input  logic              i_wr_rdy,
  output logic              o_wr_vld,
  output logic              o_en_tf,
  output logic [1:0]        o_cal_state,
  output logic [2:0]        o_layer_state,
  output logic [CNT_BW-1:0] o_tile_idx,
  output logic              o_busy,
  output logic              o_done
);
  localparam int DRAIN_CYC = drain_cyc(ROWS, COLS);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  logic [2:0] state, nxt;
  logic [2:0] nl;
  logic [CNT_BW-1:0] nt, kl;
  logic start_ok, hs, k_tc, d_tc, t_tc, l_tc;
  logic [CNT_BW-1:0] k_unused;
  logic [DW-1:0] d_unused;
  assign start_ok = state == S_IDLE && i_start;
  assign hs = state == S_WB && i_wr_rdy;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      nl <= '0;
      nt <= '0;
      kl <= '0;
    end else begin
      state <= nxt;
      if (start_ok) begin
        nl <= i_num_layers == '0 ? 3'd1 : i_num_layers;
        nt <= i_num_tiles == '0 ? CNT_BW'(1) : i_num_tiles;
        kl <= i_k_len == '0 ? CNT_BW'(1) : i_k_len;
      end
    end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = i_start ? S_MAC : S_IDLE;
      S_MAC:   nxt = i_rd_vld && k_tc ? S_DRAIN : S_MAC;
      S_DRAIN: nxt = d_tc ? S_BIAS : S_DRAIN;
      S_BIAS:  nxt = S_WB;
      S_WB:    nxt = !i_wr_rdy ? S_WB : t_tc && l_tc ? S_DONE : S_MAC;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  // K and drain counters sit at zero outside their own state, so every entry starts fresh
  pu_seq_cnt #(.W(CNT_BW)) u_k (
    .clk(clk), .rst(rst), .ld(state != S_MAC), .ld_val('0),
    .inc(state == S_MAC && i_rd_vld), .term(kl - 1'b1), .cnt(k_unused), .tc(k_tc)
  );
  pu_seq_cnt #(.W(DW)) u_drain (
    .clk(clk), .rst(rst), .ld(state != S_DRAIN), .ld_val('0),
    .inc(state == S_DRAIN), .term(DW'(DRAIN_CYC - 1)), .cnt(d_unused), .tc(d_tc)
  );
  // the final handshake leaves tile/layer untouched so DONE still shows the last position
  pu_seq_cnt #(.W(CNT_BW)) u_tile (
    .clk(clk), .rst(rst), .ld(start_ok || (hs && t_tc && !l_tc)), .ld_val('0),
    .inc(hs && !t_tc), .term(nt - 1'b1), .cnt(o_tile_idx), .tc(t_tc)
  );
  pu_seq_cnt #(.W(3)) u_layer (
    .clk(clk), .rst(rst), .ld(start_ok), .ld_val('0),
    .inc(hs && t_tc && !l_tc), .term(nl - 3'd1), .cnt(o_layer_state), .tc(l_tc)
  );
  assign o_rd_req = state == S_MAC;
  assign o_en_tf = (state == S_MAC && i_rd_vld) || state == S_DRAIN || state == S_BIAS;
  assign o_wr_vld = state == S_WB;
  assign o_cal_state = state == S_MAC || state == S_DRAIN ? CAL_MAC :
                       state == S_BIAS || state == S_WB ? CAL_BIAS : CAL_IDLE;
  assign o_busy = state != S_IDLE;
  assign o_done = state == S_DONE;
endmodule

// File: doc/pu_seq.md
PU_SEQ -- requirements
Module: pu_seq

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ROWS, 5, systolic rows.
- COLS, 5, systolic columns.
- CNT_BW, 8, tile and K counter width.
- Localparam DRAIN_CYC = ROWS+COLS-1 (9 at defaults): systolic flush cycles.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- i_start, in, 1, start request, sampled in IDLE only.
- i_num_layers, in, 3, layers to run, 1..5; 0 is treated as 1.
- i_num_tiles, in, CNT_BW, output tiles per layer; 0 is treated as 1.
- i_k_len, in, CNT_BW, MAC beats per tile; 0 is treated as 1.
- i_rd_vld, in, 1, operand buffer presents valid fmap/weight this cycle.
- o_rd_req, out, 1, operand beat requested.
- i_wr_rdy, in, 1, result sink ready.
- o_wr_vld, out, 1, PU activation output valid for writeback.
- o_en_tf, out, 1, PU transfer enable.
- o_cal_state, out, 2, PU phase: 00 idle, 10 MAC, 11 bias+activation.
- o_layer_state, out, 3, current layer index, 0-based.
- o_tile_idx, out, CNT_BW, current tile index.
- o_busy, out, 1, high in any state other than IDLE.
- o_done, out, 1, one-cycle pulse at end of the run.

Function
REQ-003 FSM states: IDLE, MAC, DRAIN, BIAS, WB, DONE; registered state, Moore outputs.
REQ-004 IDLE: on i_start=1, latch i_num_layers, i_num_tiles and i_k_len (zero-corrected); clear layer, tile and K counters; go to MAC next cycle.
REQ-005 MAC: o_rd_req=1; o_cal_state=10; o_en_tf=i_rd_vld (combinational pass-through, stall when low).
REQ-006 MAC K counter: increments per accepted beat (i_rd_vld=1); on the beat where K reaches k_len-1, go to DRAIN.
REQ-007 DRAIN: o_rd_req=0; o_en_tf=1; o_cal_state=10; exactly DRAIN_CYC cycles, then BIAS.
REQ-008 BIAS: exactly one cycle; o_cal_state=11; o_en_tf=1; then WB.
REQ-009 WB: o_wr_vld=1 held until i_wr_rdy=1; o_en_tf=0; o_cal_state=11. On the handshake cycle:
- if tile<num_tiles-1: tile+1 and go to MAC;
- else if layer<num_layers-1: tile=0, layer+1 and go to MAC;
- else go to DONE.
REQ-010 Re-entry to MAC always clears the K counter.
REQ-011 DONE: o_done=1 for one cycle, counters hold, then IDLE.
REQ-012 i_start outside IDLE is ignored; config inputs outside the IDLE start cycle are ignored.
REQ-013 o_layer_state and o_tile_idx equal the counters and change only on WB handshake or start.
REQ-014 Simultaneous events:
- i_rd_vld=1 on the last K beat transitions to DRAIN and that beat is still enabled;
- i_wr_rdy asserted before WB has no effect.
REQ-015 Cycles per tile, with no stalls and i_wr_rdy tied high: k_len + DRAIN_CYC + 1 + 1.

Reset
REQ-016 rst=1 forces state IDLE and all counters and latched config to 0 immediately, independent of clk.
REQ-017 Output values during reset: o_en_tf=0, o_rd_req=0, o_wr_vld=0, o_done=0, o_busy=0, o_cal_state=00, o_layer_state=0, o_tile_idx=0.
REQ-018 Reset asserted mid-run aborts the run with no o_done pulse; after release, the block waits in IDLE for a new i_start.

Structure
REQ-019 Shared package pu_pkg holds the state encoding, the cal_state encodings (CAL_IDLE=00, CAL_MAC=10, CAL_BIAS=11) and the DRAIN_CYC expression.
REQ-020 One sub-module, pu_seq_cnt: a loadable up-counter with terminal-count flag, instantiated for K, drain, tile and layer.

Verification
REQ-021 Single tile, no stalls: layers=1, tiles=1, k_len=4, rd_vld=1, wr_rdy=1 -> o_en_tf high 4+9+1 cycles; o_wr_vld 1 cycle; o_done 16 cycles after the start cycle.
REQ-022 Operand stalls: k_len=3, i_rd_vld pattern 1,0,0,1,1 -> exactly 3 o_en_tf beats in MAC; DRAIN entered after the 5th cycle.
REQ-023 Writeback backpressure: i_wr_rdy low for 6 cycles in WB -> o_wr_vld held 7 cycles; tile/layer unchanged until handshake.
REQ-024 Multi-layer sweep: layers=3, tiles=2 -> six WB handshakes; (layer,tile) sequence (0,0)(0,1)(1,0)(1,1)(2,0)(2,1); one o_done.
REQ-025 Zero config and reset abort: layers=0, tiles=0, k_len=0 -> behaves as 1/1/1. Reset asserted during DRAIN -> all outputs 0 same cycle, no o_done; i_start while busy -> ignored.
